spi_frame_loader: RTL and testbench

- Consumes the byte stream from the SPI slave (o_RX_DV/o_RX_Byte) and parses host packets.
- Writes RGB pixels into the LED matrix frame-buffer write port and requests buffer swaps.
- Returns a status byte to the SPI slave's TX interface at the start of every transaction.
- Sits between the SPI slave and the frame-buffer/display scan logic; runs entirely in the FPGA clock domain.

---
 rtl/spi_frame_loader.sv | 171 +++++++++++++++++
 tb/tb_spi_frame_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_loader.sv
// spi_frame_loader: parses host packets arriving as bytes from an SPI slave,
// writes RGB pixels into the frame-buffer write port, requests buffer swaps,
// and hands a status byte back to the SPI slave when each transaction starts.
//
// Handshake: i_RX_DV is a one-cycle strobe qualifying i_RX_Byte; there is no
// back-pressure. o_TX_DV, o_Wr_En and o_Swap are one-cycle strobes that
// qualify o_TX_Byte, o_Wr_Addr/o_Wr_Data and the swap request respectively.
module spi_frame_loader #(
    parameter int ADDR_WIDTH = 11,
    parameter int NUM_PIXELS = 2048
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_RX_DV,
    input  logic [7:0]            i_RX_Byte,
    input  logic                  i_SPI_CS_n,
    output logic                  o_TX_DV,
    output logic [7:0]            o_TX_Byte,
    output logic                  o_Wr_En,
    output logic [ADDR_WIDTH-1:0] o_Wr_Addr,
    output logic [23:0]           o_Wr_Data,
    output logic                  o_Swap,
    output logic                  o_Error
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_CMD       = 4'd1;
    localparam logic [3:0] S_ADDR_H    = 4'd2;
    localparam logic [3:0] S_ADDR_L    = 4'd3;
    localparam logic [3:0] S_PIX_R     = 4'd4;
    localparam logic [3:0] S_PIX_G     = 4'd5;
    localparam logic [3:0] S_PIX_B     = 4'd6;
    localparam logic [3:0] S_SWAP_WAIT = 4'd7;
    localparam logic [3:0] S_DISCARD   = 4'd8;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);

    logic                  cs_meta, cs_sync, cs_prev;
    logic                  cs_fall, cs_rise;
    logic [3:0]            state, state_n;
    logic                  error, swap_pending;
    logic [7:0]            addr_hi, pix_r, pix_g;
    logic [ADDR_WIDTH-1:0] pix_addr;
    logic [15:0]           addr_full;
    logic                  err_set, do_write, load_addr, latch_hi;
    logic                  latch_r, latch_g, swap_req;

    assign cs_fall   = cs_prev & ~cs_sync;
    assign cs_rise   = ~cs_prev & cs_sync;
    assign addr_full = {addr_hi, i_RX_Byte};
    assign o_Error   = error;

    // Two-flop synchroniser on raw chip select plus a delayed copy for edge detection.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cs_meta <= 1'b1;
            cs_sync <= 1'b1;
            cs_prev <= 1'b1;
        end else begin
            cs_meta <= i_SPI_CS_n;
            cs_sync <= cs_meta;
            cs_prev <= cs_sync;
        end
    end

    // Packet parser: the received byte is processed first, then end-of-transaction.
    always_comb begin
        state_n   = state;
        err_set   = 1'b0;
        do_write  = 1'b0;
        load_addr = 1'b0;
        latch_hi  = 1'b0;
        latch_r   = 1'b0;
        latch_g   = 1'b0;
        swap_req  = 1'b0;
        case (state)
            S_IDLE: if (cs_fall) state_n = S_CMD;
            S_CMD: if (i_RX_DV) begin
                case (i_RX_Byte)
                    8'h01:   state_n = S_ADDR_H;
                    8'h02:   state_n = S_SWAP_WAIT;
                    8'h00:   state_n = S_DISCARD;
                    default: begin
                        err_set = 1'b1;
                        state_n = S_DISCARD;
                    end
                endcase
            end
            S_ADDR_H: if (i_RX_DV) begin
                latch_hi = 1'b1;
                state_n  = S_ADDR_L;
            end
            S_ADDR_L: if (i_RX_DV) begin
                if ({16'd0, addr_full} >= 32'(NUM_PIXELS)) begin
                    err_set = 1'b1;
                    state_n = S_DISCARD;
                end else begin
                    load_addr = 1'b1;
                    state_n   = S_PIX_R;
                end
            end
            S_PIX_R: if (i_RX_DV) begin
                latch_r = 1'b1;
                state_n = S_PIX_G;
            end
            S_PIX_G: if (i_RX_DV) begin
                latch_g = 1'b1;
                state_n = S_PIX_B;
            end
            S_PIX_B: if (i_RX_DV) begin
                do_write = 1'b1;
                state_n  = S_PIX_R;
            end
            S_SWAP_WAIT: if (i_RX_DV) begin
                err_set = 1'b1;
                state_n = S_DISCARD;
            end
            S_DISCARD: state_n = S_DISCARD;
            default:   state_n = S_IDLE;
        endcase
        // An empty transaction (CMD with no byte) is harmless; one that stops
        // before the address is complete is a protocol error.
        if (cs_rise && state != S_IDLE) begin
            if (state_n == S_ADDR_H || state_n == S_ADDR_L) err_set = 1'b1;
            if (state_n == S_SWAP_WAIT) swap_req = 1'b1;
            state_n = S_IDLE;
        end
    end

    // State, status, latches, address counter and output strobes.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state        <= S_IDLE;
            error        <= 1'b0;
            swap_pending <= 1'b0;
            addr_hi      <= 8'd0;
            pix_r        <= 8'd0;
            pix_g        <= 8'd0;
            pix_addr     <= '0;
            o_TX_DV      <= 1'b0;
            o_TX_Byte    <= 8'd0;
            o_Wr_En      <= 1'b0;
            o_Wr_Addr    <= '0;
            o_Wr_Data    <= 24'd0;
            o_Swap       <= 1'b0;
        end else begin
            state   <= state_n;
            o_TX_DV <= cs_fall;
            o_Wr_En <= do_write;
            o_Swap  <= swap_req;
            // Status is read-to-clear at transaction start; a fresh error wins.
            error   <= err_set | (error & ~cs_fall);
            if (cs_fall) o_TX_Byte <= {error, swap_pending, 6'b0};
            if (swap_req) swap_pending <= 1'b1;
            else if (cs_fall) swap_pending <= 1'b0;
            if (latch_hi) addr_hi <= i_RX_Byte;
            if (latch_r) pix_r <= i_RX_Byte;
            if (latch_g) pix_g <= i_RX_Byte;
            if (load_addr) begin
                pix_addr <= addr_full[ADDR_WIDTH-1:0];
            end else if (do_write) begin
                pix_addr <= (pix_addr == LAST_ADDR) ? '0 : pix_addr + 1'b1;
            end
            if (do_write) begin
                o_Wr_Addr <= pix_addr;
                o_Wr_Data <= {pix_r, pix_g, i_RX_Byte};
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed bench for spi_frame_loader: drives byte-level SPI traffic and
// checks status bytes, pixel writes, swap requests and the error flag.
module tb_spi_frame_loader;

    localparam int AW = 11;
    localparam int W  = AW + 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          cs_n;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          swap;
    logic          error;

    int n_cmp  = 0;
    int n_fail = 0;
    int swap_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];

    spi_frame_loader #(.ADDR_WIDTH(AW), .NUM_PIXELS(2048)) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_RX_DV    (rx_dv),
        .i_RX_Byte  (rx_byte),
        .i_SPI_CS_n (cs_n),
        .o_TX_DV    (tx_dv),
        .o_TX_Byte  (tx_byte),
        .o_Wr_En    (wr_en),
        .o_Wr_Addr  (wr_addr),
        .o_Wr_Data  (wr_data),
        .o_Swap     (swap),
        .o_Error    (error)
    );

    // Clock
    always #5 clk = ~clk;

    // Capture writes and swap pulses away from the active edge
    always @(negedge clk) begin
        if (wr_en) obs_q.push_back({wr_addr, wr_data});
        if (swap) swap_cnt = swap_cnt + 1;
    end

    // Driver: lower CS and report how many status pulses appear, when, and the byte
    task automatic start_txn(output int pulses, output int when, output logic [7:0] status);
        pulses = 0;
        when   = 0;
        status = 8'hxx;
        repeat (3) @(posedge clk);
        #1 cs_n = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (tx_dv) begin
                pulses = pulses + 1;
                when   = i;
                status = tx_byte;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_byte = b;
        rx_dv = 1'b1;
        @(posedge clk);
        #1 rx_dv = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // Driver: raise CS after the last byte and count swap pulses that follow
    task automatic end_txn(output int swaps);
        int s0;
        s0 = swap_cnt;
        repeat (4) @(posedge clk);
        #1 cs_n = 1'b1;
        repeat (8) @(posedge clk);
        #1 swaps = swap_cnt - s0;
    endtask

    // Driver: raise CS so that a final byte's DV lands in the cs_rise cycle
    task automatic end_with_byte(input logic [7:0] b, output int swaps);
        int s0;
        s0 = swap_cnt;
        @(posedge clk);
        #1 cs_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rx_byte = b;
        rx_dv = 1'b1;
        @(posedge clk);
        #1 rx_dv = 1'b0;
        repeat (8) @(posedge clk);
        #1 swaps = swap_cnt - s0;
    endtask

    task automatic test_reset;
        int p, w, s;
        logic [7:0] st;
        rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({tx_dv, tx_byte, wr_en, wr_addr, wr_data, swap, error} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got tx_dv=%b tx=%h wr=%b a=%h d=%h sw=%b err=%b, want all 0",
                tx_dv, tx_byte, wr_en, wr_addr, wr_data, swap, error);
        end
        rst = 1'b0;
        start_txn(p, w, st);
        n_cmp++; if (p !== 1) begin n_fail++; $display("FAIL reset_tx_pulses: got %0d want 1", p); end
        n_cmp++; if (w !== 3) begin n_fail++; $display("FAIL reset_tx_latency: got %0d want 3", w); end
        n_cmp++; if (st !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h want 00", st); end
        end_txn(s);
    endtask

    task automatic test_write;
        int p, w, s;
        logic [7:0] st;
        logic [7:0] pkt[$] = '{8'h01, 8'h00, 8'h05, 8'hFF, 8'h10, 8'h20, 8'h00, 8'h00, 8'h01};
        exp_q.push_back({11'h005, 24'hFF1020});
        exp_q.push_back({11'h006, 24'h000001});
        start_txn(p, w, st);
        n_cmp++; if (st !== 8'h00) begin n_fail++; $display("FAIL write_status: got %h want 00", st); end
        foreach (pkt[i]) send_byte(pkt[i]);
        end_txn(s);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL write_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL write_%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL write_error: got %b want 0", error); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_wrap;
        int p, w, s;
        logic [7:0] st;
        logic [7:0] pkt[$] = '{8'h01, 8'h07, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_q.push_back({11'h7FF, 24'h112233});
        exp_q.push_back({11'h000, 24'h445566});
        start_txn(p, w, st);
        foreach (pkt[i]) send_byte(pkt[i]);
        end_txn(s);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL wrap_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_swap;
        int p, w, s;
        logic [7:0] st;
        start_txn(p, w, st);
        send_byte(8'h02);
        end_txn(s);
        n_cmp++; if (s !== 1) begin n_fail++; $display("FAIL swap_pulses: got %0d want 1", s); end
        start_txn(p, w, st);
        n_cmp++; if (st !== 8'h40) begin n_fail++; $display("FAIL swap_status_pending: got %h want 40", st); end
        end_txn(s);
        n_cmp++; if (s !== 0) begin n_fail++; $display("FAIL swap_empty_txn: got %0d swaps want 0", s); end
        start_txn(p, w, st);
        n_cmp++; if (st !== 8'h00) begin n_fail++; $display("FAIL swap_status_cleared: got %h want 00", st); end
        end_txn(s);
    endtask

    task automatic test_error;
        int p, w, s;
        logic [7:0] st;
        start_txn(p, w, st);
        send_byte(8'h7E);
        end_txn(s);
        n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL err_bad_cmd: got %b want 1", error); end
        start_txn(p, w, st);
        n_cmp++; if (st !== 8'h80) begin n_fail++; $display("FAIL err_status_1: got %h want 80", st); end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL err_read_clear: got %b want 0", error); end
        send_byte(8'h01); send_byte(8'h08); send_byte(8'h00);
        end_txn(s);
        n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL err_bad_addr: got %b want 1", error); end
        n_cmp++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL err_no_writes: got %0d want 0", obs_q.size()); end
        start_txn(p, w, st);
        n_cmp++; if (st !== 8'h80) begin n_fail++; $display("FAIL err_status_2: got %h want 80", st); end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL err_clear_2: got %b want 0", error); end
        end_txn(s);
        start_txn(p, w, st);
        n_cmp++; if (st !== 8'h00) begin n_fail++; $display("FAIL err_status_3: got %h want 00", st); end
        end_txn(s);
        obs_q.delete();
    endtask

    task automatic test_partial;
        int p, w, s;
        logic [7:0] st;
        start_txn(p, w, st);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
        end_txn(s);
        n_cmp++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL partial_no_write: got %0d want 0", obs_q.size()); end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL partial_error: got %b want 0", error); end
        obs_q.delete();
    endtask

    task automatic test_truncated;
        int p, w, s;
        logic [7:0] st;
        start_txn(p, w, st);
        send_byte(8'h01); send_byte(8'h00);
        end_txn(s);
        n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL trunc_error: got %b want 1", error); end
        start_txn(p, w, st);
        n_cmp++; if (st !== 8'h80) begin n_fail++; $display("FAIL trunc_status: got %h want 80", st); end
        end_txn(s);
    endtask

    task automatic test_same_cycle;
        int p, w, s;
        logic [7:0] st;
        exp_q.push_back({11'h00A, 24'h010203});
        start_txn(p, w, st);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h0A); send_byte(8'h01); send_byte(8'h02);
        end_with_byte(8'h03, s);
        n_cmp++; if (obs_q.size() !== 1) begin
            n_fail++; $display("FAIL edge_write_count: got %0d want 1", obs_q.size());
        end else begin
            n_cmp++; if (obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL edge_write: got %h want %h", obs_q[0], exp_q[0]); end
        end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL edge_write_error: got %b want 0", error); end
        exp_q.delete(); obs_q.delete();
        start_txn(p, w, st);
        send_byte(8'h02);
        end_with_byte(8'h55, s);
        n_cmp++; if (s !== 0) begin n_fail++; $display("FAIL edge_swap_cancel: got %0d swaps want 0", s); end
        n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL edge_swap_error: got %b want 1", error); end
        start_txn(p, w, st);
        n_cmp++; if (st !== 8'h80) begin n_fail++; $display("FAIL edge_status: got %h want 80", st); end
        end_txn(s);
    endtask

    task automatic test_reset_mid;
        int p, w, s;
        logic [7:0] st;
        start_txn(p, w, st);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h03); send_byte(8'h11);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({tx_dv, tx_byte, wr_en, wr_addr, wr_data, swap, error} !== '0) begin
            n_fail++; $display("FAIL midreset_outputs: got tx=%h wr=%b a=%h d=%h sw=%b err=%b, want all 0",
                tx_byte, wr_en, wr_addr, wr_data, swap, error);
        end
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.push_back({11'h003, 24'hAABBCC});
        start_txn(p, w, st);
        n_cmp++; if (st !== 8'h00) begin n_fail++; $display("FAIL midreset_status: got %h want 00", st); end
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        end_txn(s);
        n_cmp++; if (obs_q.size() !== 1) begin
            n_fail++; $display("FAIL midreset_count: got %0d want 1", obs_q.size());
        end else begin
            n_cmp++; if (obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL midreset_write: got %h want %h", obs_q[0], exp_q[0]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset;
        test_write;
        test_wrap;
        test_swap;
        test_error;
        test_partial;
        test_truncated;
        test_same_cycle;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
